// File: rtl/mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
// Optional early termination is enabled with MUL_EARLY_TERM_EN.
package mul_pkg;

  localparam int MUL_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    D_Z,
    D_P1,
    D_P2,
    D_M1,
    D_M2
  } digit_t;

  localparam logic [2:0] ENC_Z0  = 3'b000;
  localparam logic [2:0] ENC_P1A = 3'b001;
  localparam logic [2:0] ENC_P1B = 3'b010;
  localparam logic [2:0] ENC_P2  = 3'b011;
  localparam logic [2:0] ENC_M2  = 3'b100;
  localparam logic [2:0] ENC_M1A = 3'b101;
  localparam logic [2:0] ENC_M1B = 3'b110;
  localparam logic [2:0] ENC_Z1  = 3'b111;

  function automatic int iter_of(input int w);
    return w / 2 + 1;
  endfunction

  // {Q[1:0],q_m1} -> Booth digit
  function automatic digit_t booth_enc(input logic [2:0] b);
    digit_t d;
    d = D_Z;
    unique case (b)
      ENC_Z0,  ENC_Z1:  d = D_Z;
      ENC_P1A, ENC_P1B: d = D_P1;
      ENC_P2:           d = D_P2;
      ENC_M2:           d = D_M2;
      ENC_M1A, ENC_M1B: d = D_M1;
      default:          d = D_Z;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product select: digit times extended multiplicand.
// Negative digits return the inverted magnitude plus a carry-in.
module booth_pp_sel
  import mul_pkg::*;
#(
  parameter int XW = 34
) (
  input  logic [2:0]    bits,
  input  logic [XW-1:0] mcx,
  output logic [XW-1:0] pp,
  output logic          cin
);

  digit_t        dig;
  logic [XW-1:0] mag;
  logic          neg;

  always_comb begin
    dig = booth_enc(bits);
    mag = '0;
    neg = 1'b0;
    unique case (dig)
      D_P1: mag = mcx;
      D_P2: mag = {mcx[XW-2:0], 1'b0};
      D_M1: begin
        mag = mcx;
        neg = 1'b1;
      end
      D_M2: begin
        mag = {mcx[XW-2:0], 1'b0};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    pp  = neg ? ~mag : mag;
    cin = neg;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, W x W -> 2W, signed or unsigned.
// MUL_EARLY_TERM_EN: finish early once the remaining multiplier bits are zero.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int W    = MUL_W,
  parameter int ITER = iter_of(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   mc,
  input  logic [W-1:0]   mp,
  output logic [2*W-1:0] p,
  output logic           done,
  output logic           busy
);

  localparam int XW = W + 2;
  localparam int CW = $clog2(ITER + 1);

  state_t        state;
  logic [XW-1:0] a;
  logic [XW-1:0] q;
  logic [XW-1:0] mcx;
  logic          qm1;
  logic [CW-1:0] cnt;

  logic [XW-1:0]     pp;
  logic              cin;
  logic [XW-1:0]     sum;
  logic [2*XW+2:0]   wide;
  logic [XW-1:0]     a_n;
  logic [XW-1:0]     q_n;
  logic              qm1_n;
  logic [2*XW-1:0]   aq;
  logic [2*XW-1:0]   aq_sh;
  logic              fin;
  logic [XW-1:0]     mc_ext;
  logic [XW-1:0]     mp_ext;

  booth_pp_sel #(
    .XW(XW)
  ) u_pp (
    .bits({q[1:0], qm1}),
    .mcx (mcx),
    .pp  (pp),
    .cin (cin)
  );

  assign mc_ext = sgn ? {{2{mc[W-1]}}, mc} : {2'b00, mc};
  assign mp_ext = sgn ? {{2{mp[W-1]}}, mp} : {2'b00, mp};

  assign sum  = a + pp + {{(XW-1){1'b0}}, cin};
  // Arithmetic shift of {A,Q,q_m1} by one digit
  assign wide  = {{2{sum[XW-1]}}, sum, q, qm1};
  assign a_n   = wide[2*XW+2:XW+3];
  assign q_n   = wide[XW+2:3];
  assign qm1_n = wide[2];
  assign aq    = {a, q};

`ifdef MUL_EARLY_TERM_EN
  logic [XW-1:0] mask;
  logic          zero;
  logic [CW:0]   sh;

  // Low bits of Q that still hold unprocessed multiplier digits
  assign mask  = {XW{1'b1}} >> {cnt, 1'b0};
  assign zero  = ((q & mask) == '0) && !qm1;
  assign fin   = (cnt == CW'(ITER)) || zero;
  assign sh    = {CW'(ITER) - cnt, 1'b0};
  assign aq_sh = $unsigned($signed(aq) >>> sh);
`else
  assign fin   = (cnt == CW'(ITER));
  assign aq_sh = aq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      mcx   <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      p     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mcx   <= mc_ext;
            q     <= mp_ext;
            a     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (fin) begin
            p     <= aq_sh[2*W-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            a   <= a_n;
            q   <= q_n;
            qm1 <= qm1_n;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and small random checks for booth_mul_seq.
// Latency expectations follow MUL_EARLY_TERM_EN when defined.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] mc;
  logic [31:0] mp;
  logic [63:0] p;
  logic        done;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  booth_mul_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sgn  (sgn),
    .mc   (mc),
    .mp   (mp),
    .p    (p),
    .done (done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic kick(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    sgn   = s;
    mc    = x;
    mp    = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mc    = $urandom;
    mp    = $urandom;
    sgn   = ~s;
  endtask

  task automatic wait_done(output int e);
    e = 0;
    while (done !== 1'b1 && e < 60) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    mc    = '0;
    mp    = '0;
    #12;
    n_chk++;
    if (p !== 64'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: p=%h done=%b busy=%b want 0/0/0", p, done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_basic;
    int e;
    int lat;
`ifdef MUL_EARLY_TERM_EN
    lat = 3;
`else
    lat = 18;
`endif
    kick(1'b0, 32'd3, 32'd5);
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flags: busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(e);
    n_chk++;
    if (e != lat) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", e, lat);
    end
    n_chk++;
    if (p !== 64'h0000_0000_0000_000F || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_p: p=%h busy=%b want 000000000000000f/0", p, busy);
    end
  endtask

  task automatic test_corners;
    logic        s [6];
    logic [31:0] x [6];
    logic [31:0] y [6];
    logic [63:0] r [6];
    int e;
    s[0] = 0; x[0] = 32'hFFFF_FFFF; y[0] = 32'hFFFF_FFFF; r[0] = 64'hFFFF_FFFE_0000_0001;
    s[1] = 1; x[1] = 32'hFFFF_FFFF; y[1] = 32'hFFFF_FFFF; r[1] = 64'h0000_0000_0000_0001;
    s[2] = 1; x[2] = 32'h8000_0000; y[2] = 32'h8000_0000; r[2] = 64'h4000_0000_0000_0000;
    s[3] = 1; x[3] = 32'h8000_0000; y[3] = 32'd1;         r[3] = 64'hFFFF_FFFF_8000_0000;
    s[4] = 1; x[4] = 32'hFFFF_FFF9; y[4] = 32'd6;         r[4] = 64'hFFFF_FFFF_FFFF_FFD6;
    s[5] = 0; x[5] = 32'hFFFF_FFF9; y[5] = 32'd6;         r[5] = 64'h0000_0005_FFFF_FFD6;
    for (int i = 0; i < 6; i++) begin
      kick(s[i], x[i], y[i]);
      wait_done(e);
      n_chk++;
      if (p !== r[i]) begin
        n_fail++;
        $display("FAIL corner%0d: p=%h want %h", i, p, r[i]);
      end
    end
    kick(1'b0, 32'hDEAD_BEEF, 32'd0);
    wait_done(e);
    n_chk++;
    if (p !== 64'd0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mp: p=%h done=%b want 0/1", p, done);
    end
  endtask

  task automatic test_back_to_back;
    int e;
    int lat;
`ifdef MUL_EARLY_TERM_EN
    lat = 17;
`else
    lat = 18;
`endif
    kick(1'b0, 32'd3, 32'h4000_0000);
    e = 0;
    while (done !== 1'b1 && e < 60) begin
      @(negedge clk);
      start = (e == 4 || e == 8) ? 1'b1 : 1'b0;
      mc    = 32'd99;
      mp    = 32'd99;
      @(posedge clk);
      #1;
      e++;
    end
    start = 1'b0;
    n_chk++;
    if (e != lat) begin
      n_fail++;
      $display("FAIL ignore_latency: got %0d want %0d", e, lat);
    end
    n_chk++;
    if (p !== 64'h0000_0000_C000_0000) begin
      n_fail++;
      $display("FAIL ignore_p: p=%h want 00000000c0000000", p);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: done=%b busy=%b want 1/0", done, busy);
    end
    kick(1'b0, 32'd7, 32'd6);
    n_chk++;
    if (done !== 1'b0 || p !== 64'h0000_0000_C000_0000) begin
      n_fail++;
      $display("FAIL restart: done=%b p=%h want 0/00000000c0000000", done, p);
    end
    wait_done(e);
    n_chk++;
    if (p !== 64'd42) begin
      n_fail++;
      $display("FAIL restart_p: p=%h want 2a", p);
    end
  endtask

  task automatic test_async_reset;
    int e;
    kick(1'b0, 32'd5, 32'h8000_0001);
    repeat (9) @(posedge clk);
    #2;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (p !== 64'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: p=%h done=%b busy=%b want 0/0/0", p, done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    kick(1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done(e);
    n_chk++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      n_fail++;
      $display("FAIL post_reset_p: p=%h want fffffffffffffff1", p);
    end
  endtask

  task automatic test_early_term;
    int e;
    int lat;
`ifdef MUL_EARLY_TERM_EN
    lat = 2;
`else
    lat = 18;
`endif
    kick(1'b0, 32'h1234_5678, 32'd1);
    wait_done(e);
    n_chk++;
    if (e != lat) begin
      n_fail++;
      $display("FAIL early_latency: got %0d want %0d", e, lat);
    end
    n_chk++;
    if (p !== 64'h0000_0000_1234_5678) begin
      n_fail++;
      $display("FAIL early_p: p=%h want 0000000012345678", p);
    end
  endtask

  task automatic test_random;
    logic [31:0]        x;
    logic [31:0]        y;
    logic               s;
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic [63:0]        r;
    int e;
    for (int i = 0; i < 200; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) y = y >> $urandom_range(31, 8);
      s = i[0];
      if (s) begin
        sx = $signed(x);
        sy = $signed(y);
        r  = sx * sy;
      end else begin
        r = {32'd0, x} * {32'd0, y};
      end
      kick(s, x, y);
      wait_done(e);
      n_chk++;
      if (done !== 1'b1 || p !== r) begin
        n_fail++;
        $display("FAIL rand%0d: s=%b %h*%h p=%h done=%b want %h", i, s, x, y, p, done, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_async_reset();
    test_early_term();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
